// File: rtl/router_pkt_tx.sv
// Packet transmitter for the 1x3 router: buffers a payload, then sends header, payload, parity.
// Optional macro ROUTER_PKT_TX_ERR_INJECT_EN adds inj_parity_err to force an inverted parity byte.
module router_pkt_tx #(
  parameter int unsigned MAX_LEN    = 63,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_addr,
  input  logic [5:0]  cmd_len,
  output logic        cmd_err,
  input  logic        pay_valid,
  output logic        pay_ready,
  input  logic [7:0]  pay_data,
  input  logic        busy,
  output logic        packet_valid,
  output logic [7:0]  data_out,
  output logic        tx_done,
  output logic        tx_active,
  output logic [15:0] pkt_count
`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
  ,
  input  logic        inj_parity_err
`endif
);

  localparam int unsigned DEPTH    = MAX_LEN + 1;
  localparam logic [3:0]  GAP_LAST = 4'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HEADER, S_PAYLOAD, S_PARITY, S_GAP
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  len_q, len_d;
  logic [1:0]  addr_q, addr_d;
  logic [5:0]  wr_q, wr_d;
  logic [5:0]  rd_q, rd_d;
  logic [7:0]  parity_q, parity_d;
  logic [3:0]  gap_q, gap_d;
  logic        inj_q, inj_d;
  logic        pv_q, pv_d;
  logic [7:0]  dout_q, dout_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  mem_q [DEPTH];
  logic        cmd_fire, pay_fire, inj_sel;

`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
  assign inj_sel = inj_parity_err;
`else
  assign inj_sel = 1'b0;
`endif

  assign cmd_ready    = (state_q == S_IDLE) && !rst;
  assign pay_ready    = (state_q == S_LOAD);
  assign tx_active    = (state_q == S_HEADER) || (state_q == S_PAYLOAD) || (state_q == S_PARITY);
  assign cmd_fire     = cmd_valid && cmd_ready;
  assign pay_fire     = pay_valid && pay_ready;
  assign packet_valid = pv_q;
  assign data_out     = dout_q;
  assign tx_done      = done_q;
  assign cmd_err      = err_q;
  assign pkt_count    = cnt_q;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    parity_d = parity_q;
    gap_d    = gap_q;
    inj_d    = inj_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          len_d  = cmd_len;
          addr_d = cmd_addr;
          inj_d  = inj_sel;
          if (cmd_addr == 2'd3) begin
            err_d = 1'b1;
          end else begin
            parity_d = {cmd_len, cmd_addr};
            wr_d     = '0;
            rd_d     = '0;
            state_d  = (cmd_len != '0) ? S_LOAD : S_HEADER;
          end
        end
      end
      S_LOAD: begin
        if (pay_fire) begin
          parity_d = parity_q ^ pay_data;
          wr_d     = wr_q + 6'd1;
          if (wr_q + 6'd1 == len_q) state_d = S_HEADER;
        end
      end
      S_HEADER: begin
        if (!busy) state_d = (len_q != '0) ? S_PAYLOAD : S_PARITY;
      end
      S_PAYLOAD: begin
        if (!busy) begin
          rd_d = rd_q + 6'd1;
          if (rd_q + 6'd1 == len_q) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (!busy) begin
          cnt_d   = cnt_q + 16'd1;
          done_d  = 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Router-facing outputs are decoded from the next state so they register
    // in the same edge as the transition; while busy the state holds, so they hold too.
    pv_d   = 1'b0;
    dout_d = '0;
    unique case (state_d)
      S_HEADER: begin
        pv_d   = 1'b1;
        dout_d = {len_d, addr_d};
      end
      S_PAYLOAD: begin
        pv_d   = 1'b1;
        dout_d = mem_q[rd_d];
      end
      S_PARITY: dout_d = inj_d ? ~parity_d : parity_d;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      addr_q   <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      parity_q <= '0;
      gap_q    <= '0;
      inj_q    <= 1'b0;
      pv_q     <= 1'b0;
      dout_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      parity_q <= parity_d;
      gap_q    <= gap_d;
      inj_q    <= inj_d;
      pv_q     <= pv_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pay_fire && !rst) mem_q[wr_q] <= pay_data;
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: expected router bytes are queued at command time
// and compared by a monitor as each byte is presented.
module tb_router_pkt_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_addr;
  logic [5:0]  cmd_len;
  logic        cmd_err;
  logic        pay_valid;
  logic        pay_ready;
  logic [7:0]  pay_data;
  logic        busy;
  logic        packet_valid;
  logic [7:0]  data_out;
  logic        tx_done;
  logic        tx_active;
  logic [15:0] pkt_count;
`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
  logic        inj_parity_err;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [8:0]  exp_q[$];
  logic        done_exp = 1'b0;
  logic [7:0]  pl [64];
  int unsigned exp_cnt = 0;

  always #5 clk = ~clk;

  router_pkt_tx #(.MAX_LEN(63), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_err(cmd_err),
    .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
    .busy(busy), .packet_valid(packet_valid), .data_out(data_out),
    .tx_done(tx_done), .tx_active(tx_active), .pkt_count(pkt_count)
`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
    , .inj_parity_err(inj_parity_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: a presented byte transfers at the next edge when busy is low.
  always @(negedge clk) begin
    check("tx_done", {31'd0, tx_done}, {31'd0, done_exp});
    done_exp = 1'b0;
    if (tx_active) begin
      check("byte_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        check("router_byte", {23'd0, packet_valid, data_out}, {23'd0, exp_q[0]});
        if (!busy) begin
          if (exp_q[0][8] == 1'b0) done_exp = 1'b1;
          void'(exp_q.pop_front());
        end
      end
    end else begin
      check("idle_out", {23'd0, packet_valid, data_out}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] a, input logic [5:0] l, input logic inj);
    int unsigned w = 0;
    logic [7:0] par;
    while (!cmd_ready && w < 200) begin
      tick();
      w++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    if (a != 2'd3) begin
      par = {l, a};
      exp_q.push_back({1'b1, l, a});
      for (int i = 0; i < int'(l); i++) begin
        exp_q.push_back({1'b1, pl[i]});
        par = par ^ pl[i];
      end
      exp_q.push_back({1'b0, inj ? ~par : par});
    end
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
    inj_parity_err = inj;
`endif
    tick();
    cmd_valid = 1'b0;
`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
    inj_parity_err = 1'b0;
`endif
  endtask

  task automatic load(input logic [5:0] l, input logic [7:0] hdr);
    for (int i = 0; i < int'(l); i++) begin
      if (i == 2) begin
        pay_valid = 1'b0;
        tick();
      end
      check("pay_ready", {31'd0, pay_ready}, 32'd1);
      pay_valid = 1'b1;
      pay_data  = pl[i];
      tick();
    end
    pay_valid = 1'b0;
    check("pay_ready_off", {31'd0, pay_ready}, 32'd0);
    check("hdr_latency", {23'd0, packet_valid, data_out}, {23'd0, 1'b1, hdr});
  endtask

  task automatic wait_done();
    int unsigned w = 0;
    while (!tx_done && w < 500) begin
      tick();
      w++;
    end
    check("tx_done_seen", {31'd0, tx_done}, 32'd1);
    exp_cnt++;
    check("pkt_count", {16'd0, pkt_count}, {16'd0, exp_cnt[15:0]});
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic wait_presented(input logic [7:0] b);
    int unsigned w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(tx_active && data_out == b) && w < 200);
    check("presented_seen", {31'd0, tx_active && data_out == b}, 32'd1);
  endtask

  task automatic seq_payload();
    for (int i = 0; i < 64; i++) pl[i] = 8'(i + 1);
  endtask

  initial begin
    int unsigned n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    pay_valid = 1'b0; pay_data = '0; busy = 1'b0;
`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
    inj_parity_err = 1'b0;
`endif
    tick();
    tick();
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_outputs", {7'd0, packet_valid, data_out, pkt_count}, 32'd0);
    check("rst_pulses", {29'd0, tx_done, cmd_err, tx_active}, 32'd0);
    rst = 1'b0;
    #1;
    check("cmd_ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // basic packet, addr 0, len 8
    seq_payload();
    issue(2'd0, 6'd8, 1'b0);
    load(6'd8, 8'h20);
    wait_done();

    // same packet with busy held over byte 0x03
    issue(2'd0, 6'd8, 1'b0);
    load(6'd8, 8'h20);
    wait_presented(8'h02);
    @(posedge clk);
    #1;
    busy = 1'b1;
    tick();
    tick();
    tick();
    check("busy_hold", {23'd0, packet_valid, data_out}, {23'd0, 9'h103});
    busy = 1'b0;
    wait_done();

    // illegal address
    issue(2'd3, 6'd5, 1'b0);
    check("cmd_err_pulse", {29'd0, cmd_err, pay_ready, packet_valid}, 32'd4);
    tick();
    check("cmd_err_clear", {30'd0, cmd_err, cmd_ready}, 32'd1);
    check("pkt_count_illegal", {16'd0, pkt_count}, {16'd0, exp_cnt[15:0]});

    // zero-length packet
    issue(2'd2, 6'd0, 1'b0);
    check("hdr_latency_len0", {23'd0, packet_valid, data_out}, {23'd0, 9'h102});
    wait_done();

    // reset mid-payload
    issue(2'd0, 6'd8, 1'b0);
    load(6'd8, 8'h20);
    wait_presented(8'h03);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    exp_q.delete();
    exp_cnt = 0;
    check("abort_outputs", {7'd0, packet_valid, data_out, pkt_count}, 32'd0);
    check("abort_cmd_ready", {30'd0, cmd_ready, tx_active}, 32'd0);
    rst = 1'b0;
    #1;
    check("abort_cmd_ready_rel", {31'd0, cmd_ready}, 32'd1);
    issue(2'd0, 6'd8, 1'b0);
    load(6'd8, 8'h20);
    wait_done();

    // random payload, then back-to-back command to observe the gap
    for (int i = 0; i < 5; i++) pl[i] = 8'($urandom_range(0, 255));
    issue(2'd1, 6'd5, 1'b0);
    load(6'd5, {6'd5, 2'd1});
    wait_done();
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check("gap_cycles", n, 32'd2);
    issue(2'd2, 6'd0, 1'b0);
    wait_done();

`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
    seq_payload();
    issue(2'd0, 6'd8, 1'b1);
    load(6'd8, 8'h20);
    wait_done();
    issue(2'd0, 6'd8, 1'b0);
    load(6'd8, 8'h20);
    wait_done();
`endif

    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Packet transmitter that drives the input side of the 1x3 router (packet_valid / datain / busy).
- Accepts a command (destination address, payload length) and buffers the payload bytes from an upstream byte stream.
- Emits a complete router packet: header, then payload, then parity. The parity byte is the XOR of header and all payload bytes.
- Honours router busy back-pressure. Used as the stimulus/initiator block in front of router_top.

Parameters:
MAX_LEN, 63, maximum payload length; fixes buffer depth at 64 bytes (6-bit length field).
GAP_CYCLES, 2, idle cycles forced after each parity byte before the next command is accepted (range 1..15).

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
cmd_valid  input  1  command request.
cmd_ready  output  1  high only in IDLE with rst low.
cmd_addr  input  2  destination port; 3 is illegal.
cmd_len  input  6  payload length, 0..63.
cmd_err  output  1  one-cycle pulse when a command with cmd_addr==3 is accepted.
pay_valid  input  1  upstream payload byte valid.
pay_ready  output  1  high in LOAD only.
pay_data  input  8  payload byte.
busy  input  1  router back-pressure.
packet_valid  output  1  registered; to router packet_valid.
data_out  output  8  registered; to router datain.
tx_done  output  1  one-cycle pulse on the cycle after the parity byte transfers.
tx_active  output  1  high in HEADER, PAYLOAD and PARITY.
pkt_count  output  16  completed packets; wraps 0xFFFF -> 0.

Behaviour:
- Reset (rst=1 at an edge): next cycle state=IDLE and all outputs are 0, including pkt_count and cmd_ready. Buffer pointers and parity are cleared. Buffer contents are don't-care.
- Reset mid-packet aborts the packet immediately; the router sees a truncated packet. This is accepted behaviour. pkt_count is not incremented for the aborted packet.
- Transfer rule: a presented byte transfers at a rising edge where state is HEADER, PAYLOAD or PARITY and busy==0. While busy==1, data_out and packet_valid hold their values unchanged. No byte is ever skipped or duplicated.
- IDLE: packet_valid=0, data_out=0.
  - Command handshake completes on cmd_valid & cmd_ready; cmd_addr and cmd_len are latched.
  - addr==3: cmd_err pulses next cycle, state stays IDLE, nothing is transmitted.
  - Legal addr: parity is set to the header byte {len,addr}. Next state is LOAD if len>0, else HEADER.
- LOAD: pay_ready=1. On each pay_valid & pay_ready: buf[wr]=pay_data, parity^=pay_data, wr++. When len bytes have been written, go to HEADER. Arbitrary pay_valid gaps are tolerated.
- HEADER: packet_valid=1, data_out={len,addr}. On transfer: go to PAYLOAD (len>0) or PARITY (len==0).
- PAYLOAD: packet_valid=1, data_out=buf[rd]. rd advances on each transfer; after the len-th transfer go to PARITY.
  - Payload is fully buffered beforehand, so packet_valid never drops mid-payload.
- PARITY: packet_valid=0, data_out=parity. On transfer: pkt_count++, tx_done pulses next cycle, go to GAP.
- GAP: packet_valid=0, data_out=0 for GAP_CYCLES cycles, then IDLE.
- First header byte appears one cycle after the last LOAD write, or one cycle after command acceptance when len==0.
- Signals driven to the router are registered outputs with no combinational paths. cmd_ready and pay_ready are state decodes, with cmd_ready additionally gated by rst.

Optional Feature:
Macro: ROUTER_PKT_TX_ERR_INJECT_EN.
- Defined: an extra input inj_parity_err (1 bit) is sampled at command acceptance. If it is 1, the transmitted parity byte is ~parity; this exercises router err detection. All other behaviour is unchanged.
- Undefined: the port does not exist and parity is always correct.

Test Plan:
1. addr=0, len=8, payload 0x01..0x08, busy=0 -> header 0x20, bytes 01..08 with packet_valid=1, parity 0x28 with packet_valid=0, tx_done pulse, pkt_count=1.
2. As test 1 but busy=1 for 3 cycles while payload byte 0x03 is presented -> 0x03 held 4 cycles, sequence intact, parity 0x28.
3. cmd_addr=3, len=5 -> cmd_err pulses one cycle, pay_ready stays 0, packet_valid stays 0, pkt_count unchanged.
4. addr=2, len=0 -> header 0x02, then parity 0x02 with packet_valid=0, no payload bytes, pkt_count incremented.
5. rst asserted during payload byte 4 of a len=8 packet -> next cycle packet_valid=0, data_out=0, pkt_count=0. After release, cmd_ready=1 and a new packet per test 1 completes correctly.
6. With ROUTER_PKT_TX_ERR_INJECT_EN and inj_parity_err=1 on test 1 stimulus -> parity byte 0xD7, all other bytes identical. Two back-to-back commands -> at least GAP_CYCLES cycles of packet_valid=0 after each parity byte.
